// File: rtl/psram_scheduler.sv
// psram_scheduler: sequencer/arbiter sharing the PSRAM command port between the
// acquisition burst writer and the single-word readout requester.
module psram_scheduler #(
  parameter int                    ADDR_WIDTH = 23,
  parameter int                    ADDR_STEP  = 2,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR   = 23'h7FFFFE,
  parameter int                    WR_STREAK  = 4,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                  clk_PSRAM,
  input  logic                  rst_n,
  input  logic                  qpi_on,
  input  logic                  endcommand,
  input  logic                  next_write,
  input  logic                  wr_req,
  input  logic                  acq_enable,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [1:0]            read_write,
  output logic                  quad_start,
  output logic                  burst_mode,
  output logic                  stop_acquisition,
  output logic                  rd_ack,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  mem_full,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int STREAK_W      = $clog2(WR_STREAK + 1);
  localparam int TMO_W         = $clog2(TIMEOUT + 1);
  localparam int SETTLE_W      = 6;
  localparam int SETTLE_CYCLES = 32;
  localparam logic [ADDR_WIDTH:0] MAX_EXT  = {1'b0, MAX_ADDR};
  localparam logic [ADDR_WIDTH:0] STEP_EXT = (ADDR_WIDTH + 1)'(ADDR_STEP);
  localparam logic [ADDR_WIDTH:0] SAT_EXT  = MAX_EXT + STEP_EXT;
  // If MAX_ADDR + ADDR_STEP does not fit the pointer width, park on the top address;
  // mem_full is the authoritative indication in that case.
  localparam logic [ADDR_WIDTH-1:0] SAT_PTR =
    SAT_EXT[ADDR_WIDTH] ? {ADDR_WIDTH{1'b1}} : SAT_EXT[ADDR_WIDTH-1:0];

  typedef enum logic [2:0] {
    WAIT_INIT, IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic                  memFull_q, memFull_d;
  logic                  stopAcq_q, stopAcq_d;
  logic                  rdAck_q, rdAck_d;
  logic                  timeoutErr_q, timeoutErr_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic [TMO_W-1:0]      tmoCnt_q, tmoCnt_d;
  logic [SETTLE_W-1:0]   settleCnt_q, settleCnt_d;
  logic                  endSeen_q, endSeen_d;
  logic                  dead_q, dead_d;
  logic                  acqPrev_q, acqPrev_d;

  logic                  settled, canGrant, wrElig, grantWr, grantRd;
  logic                  waiting, cmdTimeout, cmdEnd, acqRise, ptrOverflow;
  logic [ADDR_WIDTH:0]   ptrNext;

  // After reset the driver may still be finishing an old command, so the first
  // grant waits for an endcommand or 32 cycles. dead_q enforces the gap cycle.
  assign settled     = endSeen_q || (settleCnt_q == SETTLE_W'(SETTLE_CYCLES));
  assign canGrant    = (state_q == IDLE) && qpi_on && settled && !dead_q;
  assign wrElig      = wr_req && acq_enable && !memFull_q;
  assign grantRd     = canGrant && rd_req && (!wrElig || (streak_q == STREAK_W'(WR_STREAK)));
  assign grantWr     = canGrant && wrElig && !grantRd;
  assign waiting     = (state_q == WR_WAIT) || (state_q == RD_WAIT);
  assign cmdTimeout  = waiting && !endcommand && (tmoCnt_q == TMO_W'(TIMEOUT - 1));
  assign cmdEnd      = waiting && (endcommand || cmdTimeout);
  assign acqRise     = acq_enable && !acqPrev_q;
  assign ptrNext     = {1'b0, wrPtr_q} + STEP_EXT;
  assign ptrOverflow = ptrNext > MAX_EXT;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_PSRAM or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_INIT;
      address_q    <= '0;
      wrPtr_q      <= '0;
      memFull_q    <= 1'b0;
      stopAcq_q    <= 1'b0;
      rdAck_q      <= 1'b0;
      timeoutErr_q <= 1'b0;
      streak_q     <= '0;
      tmoCnt_q     <= '0;
      settleCnt_q  <= '0;
      endSeen_q    <= 1'b0;
      dead_q       <= 1'b0;
      acqPrev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      wrPtr_q      <= wrPtr_d;
      memFull_q    <= memFull_d;
      stopAcq_q    <= stopAcq_d;
      rdAck_q      <= rdAck_d;
      timeoutErr_q <= timeoutErr_d;
      streak_q     <= streak_d;
      tmoCnt_q     <= tmoCnt_d;
      settleCnt_q  <= settleCnt_d;
      endSeen_q    <= endSeen_d;
      dead_q       <= dead_d;
      acqPrev_q    <= acqPrev_d;
    end
  end

  // Next-state logic; a dropped qpi_on only takes effect between commands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_INIT: if (qpi_on) state_d = IDLE;
      IDLE: begin
        if (!qpi_on)      state_d = WAIT_INIT;
        else if (grantWr) state_d = WR_ISSUE;
        else if (grantRd) state_d = RD_ISSUE;
      end
      WR_ISSUE: state_d = WR_WAIT;
      RD_ISSUE: state_d = RD_WAIT;
      WR_WAIT, RD_WAIT: if (cmdEnd) state_d = qpi_on ? IDLE : WAIT_INIT;
      default: state_d = WAIT_INIT;
    endcase
  end

  // Command-port outputs decoded from the current state. busy covers only states
  // with a command in flight, so it reads 0 while waiting for initialisation.
  always_comb begin
    read_write = 2'd0;
    quad_start = 1'b0;
    burst_mode = 1'b0;
    busy       = 1'b0;
    case (state_q)
      WR_ISSUE: begin read_write = 2'd1; quad_start = 1'b1; burst_mode = 1'b1; busy = 1'b1; end
      WR_WAIT:  begin read_write = 2'd1; burst_mode = 1'b1; busy = 1'b1; end
      RD_ISSUE: begin read_write = 2'd2; quad_start = 1'b1; busy = 1'b1; end
      RD_WAIT:  begin read_write = 2'd2; busy = 1'b1; end
      default: ;
    endcase
  end

  // Pointer, full/stop flags, streak, timeout and settle bookkeeping.
  always_comb begin
    address_d    = address_q;
    wrPtr_d      = wrPtr_q;
    memFull_d    = memFull_q;
    stopAcq_d    = 1'b0;
    rdAck_d      = (state_q == RD_WAIT) && endcommand;
    timeoutErr_d = timeoutErr_q || cmdTimeout;
    streak_d     = streak_q;
    tmoCnt_d     = '0;
    settleCnt_d  = settleCnt_q;
    endSeen_d    = endSeen_q || endcommand;
    dead_d       = cmdEnd;
    acqPrev_d    = acq_enable;

    if (settleCnt_q != SETTLE_W'(SETTLE_CYCLES)) settleCnt_d = settleCnt_q + 1'b1;

    if (acqRise) begin
      wrPtr_d   = '0;
      memFull_d = 1'b0;
    end else if ((state_q == WR_WAIT) && next_write) begin
      if (ptrOverflow) begin
        wrPtr_d   = SAT_PTR;
        memFull_d = 1'b1;
      end else begin
        wrPtr_d = ptrNext[ADDR_WIDTH-1:0];
      end
    end

    if ((state_q == WR_WAIT) && !cmdEnd)
      stopAcq_d = stopAcq_q || !acq_enable || (next_write && ptrOverflow);

    if (waiting && !cmdEnd) tmoCnt_d = tmoCnt_q + 1'b1;

    if (grantWr)      address_d = wrPtr_d;
    else if (grantRd) address_d = rd_addr;

    if (!rd_req || grantRd) streak_d = '0;
    else if (grantWr)       streak_d = streak_q + 1'b1;
  end

  assign address          = address_q;
  assign wr_ptr           = wrPtr_q;
  assign mem_full         = memFull_q;
  assign stop_acquisition = stopAcq_q;
  assign rd_ack           = rdAck_q;
  assign timeout_err      = timeoutErr_q;

endmodule

// File: tb/tb_psram_scheduler.sv
// Testbench for psram_scheduler: directed scenarios followed by randomized
// command traffic checked against a transaction-level reference model.
module tb_psram_scheduler;

  localparam int              AW        = 23;
  localparam int              STEP      = 2;
  localparam logic [AW-1:0]   MAX_ADDR  = 23'h00000A;
  localparam int              WR_STREAK = 4;
  localparam int              TIMEOUT   = 255;

  logic          clk_PSRAM = 1'b0;
  logic          rst_n, qpi_on, endcommand, next_write, wr_req, acq_enable, rd_req;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] address, wr_ptr;
  logic [1:0]    read_write;
  logic          quad_start, burst_mode, stop_acquisition, rd_ack, mem_full, timeout_err, busy;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: words written since the last acquisition start,
  // consecutive writes granted while a read waits, and the pending read.
  int            mWords;
  int            mStreak;
  bit            rdPending;
  bit            expWrite;
  logic [AW-1:0] expRdAddr;

  psram_scheduler #(
    .ADDR_WIDTH(AW), .ADDR_STEP(STEP), .MAX_ADDR(MAX_ADDR),
    .WR_STREAK(WR_STREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_PSRAM(clk_PSRAM), .rst_n(rst_n), .qpi_on(qpi_on), .endcommand(endcommand),
    .next_write(next_write), .wr_req(wr_req), .acq_enable(acq_enable), .rd_req(rd_req),
    .rd_addr(rd_addr), .address(address), .read_write(read_write), .quad_start(quad_start),
    .burst_mode(burst_mode), .stop_acquisition(stop_acquisition), .rd_ack(rd_ack),
    .wr_ptr(wr_ptr), .mem_full(mem_full), .timeout_err(timeout_err), .busy(busy)
  );

  // 84 MHz is approximated by a 10-unit period; only cycle counts matter here.
  always #5 clk_PSRAM = ~clk_PSRAM;

  // One place where every comparison is counted and every mismatch reported.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1 unit after the edge.
  task automatic tick();
    @(posedge clk_PSRAM);
    #1;
  endtask

  task automatic endCommand();
    endcommand = 1'b1;
    tick();
    endcommand = 1'b0;
  endtask

  task automatic pulseWrite();
    next_write = 1'b1;
    tick();
    next_write = 1'b0;
  endtask

  task automatic toggleAcq();
    acq_enable = 1'b0;
    tick();
    acq_enable = 1'b1;
    tick();
  endtask

  // Wait, with a cycle budget, for the next command start pulse.
  task automatic waitQuad(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      tick();
      if (quad_start) found = 1'b1;
    end
    checkOutput("grantSeen", found, 1);
  endtask

  function automatic int expPtr();
    int p;
    p = mWords * STEP;
    return (p > int'(MAX_ADDR) + STEP) ? int'(MAX_ADDR) + STEP : p;
  endfunction

  function automatic bit expFull();
    return (mWords * STEP) > int'(MAX_ADDR);
  endfunction

  // Drive random requests for the next grant and predict who wins it.
  task automatic applyStimulus();
    bit w, r, wElig;
    w = 1'($urandom_range(0, 1));
    r = rdPending ? 1'b1 : ($urandom_range(0, 2) == 0);
    wElig = w && !expFull();
    if (!wElig && !r) r = 1'b1;
    if (r && !rdPending) begin
      rd_addr   = AW'($urandom());
      expRdAddr = rd_addr;
    end
    rdPending = r;
    wr_req    = w;
    rd_req    = r;
    if (!r) mStreak = 0;
    if (r && (!wElig || mStreak == WR_STREAK)) begin
      expWrite = 1'b0;
      mStreak  = 0;
    end else begin
      expWrite = 1'b1;
      if (r) mStreak++;
    end
  endtask

  task automatic checkGrant(output bit isWrite);
    bit found;
    waitQuad(6, found);
    checkOutput("rndKind", read_write, expWrite ? 1 : 2);
    checkOutput("rndAddr", address, expWrite ? expPtr() : expRdAddr);
    isWrite = expWrite;
    if (!expWrite) rdPending = 1'b0;
  endtask

  initial begin
    bit found, curWrite, stopExp, withEnd;
    int quadCount, nw;
    bit grantPattern [10];

    rst_n = 1'b0; qpi_on = 1'b0; endcommand = 1'b0; next_write = 1'b0;
    wr_req = 1'b1; acq_enable = 1'b1; rd_req = 1'b0; rd_addr = '0;
    repeat (3) tick();

    // Reset values.
    checkOutput("rstAddress", address, 0);
    checkOutput("rstReadWrite", read_write, 0);
    checkOutput("rstQuadStart", quad_start, 0);
    checkOutput("rstBurst", burst_mode, 0);
    checkOutput("rstStop", stop_acquisition, 0);
    checkOutput("rstRdAck", rd_ack, 0);
    checkOutput("rstWrPtr", wr_ptr, 0);
    checkOutput("rstFull", mem_full, 0);
    checkOutput("rstTimeout", timeout_err, 0);
    checkOutput("rstBusy", busy, 0);

    // Nothing may start before initialisation completes.
    rst_n = 1'b1;
    quadCount = 0;
    repeat (100) begin
      tick();
      if (quad_start) quadCount++;
    end
    checkOutput("t1NoStart", quadCount, 0);
    qpi_on = 1'b1;
    tick();
    checkOutput("t1Early", quad_start, 0);
    tick();
    checkOutput("t1Quad", quad_start, 1);
    checkOutput("t1Rw", read_write, 1);
    checkOutput("t1Addr", address, 0);
    checkOutput("t1Burst", burst_mode, 1);

    // Five-word burst.
    wr_req = 1'b0;
    tick();
    checkOutput("t2QuadLow", quad_start, 0);
    repeat (5) pulseWrite();
    checkOutput("t2RwHeld", read_write, 1);
    checkOutput("t2AddrHeld", address, 0);
    endCommand();
    checkOutput("t2WrPtr", wr_ptr, 10);
    checkOutput("t2RwIdle", read_write, 0);
    checkOutput("t2Busy", busy, 0);
    checkOutput("t2Stop", stop_acquisition, 0);

    // Single read with exact rd_ack timing.
    rd_req = 1'b1; rd_addr = 23'h000100;
    waitQuad(6, found);
    checkOutput("t3Rw", read_write, 2);
    checkOutput("t3Addr", address, 23'h000100);
    tick();
    tick();
    endcommand = 1'b1;
    checkOutput("t3AckEarly", rd_ack, 0);
    tick();
    endcommand = 1'b0;
    checkOutput("t3Ack", rd_ack, 1);
    rd_req = 1'b0;
    tick();
    checkOutput("t3AckPulse", rd_ack, 0);

    // Both requesters busy: four writes, then the waiting read.
    grantPattern = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    wr_req = 1'b1; rd_req = 1'b1; rd_addr = 23'h000200;
    for (int g = 0; g < 10; g++) begin
      waitQuad(8, found);
      checkOutput($sformatf("t4Grant%0d", g), read_write, grantPattern[g] ? 1 : 2);
      if (g == 9) begin wr_req = 1'b0; rd_req = 1'b0; end
      tick();
      endCommand();
    end

    // Fill memory, confirm writes are locked out but reads are not, then restart.
    toggleAcq();
    checkOutput("t5PtrCleared", wr_ptr, 0);
    wr_req = 1'b1;
    waitQuad(6, found);
    checkOutput("t5Rw", read_write, 1);
    wr_req = 1'b0;
    tick();
    for (int p = 1; p <= 8; p++) begin
      pulseWrite();
      checkOutput($sformatf("t5Stop%0d", p), stop_acquisition, (p >= 6) ? 1 : 0);
    end
    checkOutput("t5Full", mem_full, 1);
    checkOutput("t5PtrSat", wr_ptr, 12);
    endCommand();
    checkOutput("t5StopClear", stop_acquisition, 0);
    wr_req = 1'b1;
    quadCount = 0;
    repeat (20) begin
      tick();
      if (quad_start) quadCount++;
    end
    checkOutput("t5NoWrite", quadCount, 0);
    rd_req = 1'b1; rd_addr = 23'h000055;
    waitQuad(6, found);
    checkOutput("t5ReadRw", read_write, 2);
    checkOutput("t5ReadAddr", address, 23'h000055);
    rd_req = 1'b0;
    tick();
    endCommand();
    checkOutput("t5ReadAck", rd_ack, 1);
    wr_req = 1'b0;
    toggleAcq();
    checkOutput("t5FullCleared", mem_full, 0);
    checkOutput("t5PtrReset", wr_ptr, 0);

    // Randomized traffic against the reference model.
    mWords = 0; mStreak = 0; rdPending = 1'b0;
    applyStimulus();
    checkGrant(curWrite);
    for (int k = 0; k < 80; k++) begin
      tick();
      stopExp = 1'b0;
      withEnd = 1'b0;
      if (curWrite) begin
        nw = $urandom_range(0, 4);
        withEnd = (nw > 0) && ($urandom_range(0, 1) == 1);
        for (int i = 0; i < nw - int'(withEnd); i++) begin
          pulseWrite();
          mWords++;
          if (mWords * STEP > int'(MAX_ADDR)) stopExp = 1'b1;
        end
        checkOutput("rndStop", stop_acquisition, stopExp);
      end else if ($urandom_range(0, 3) == 0) begin
        toggleAcq();
        mWords = 0;
      end
      repeat ($urandom_range(0, 3)) tick();
      next_write = withEnd;
      endCommand();
      next_write = 1'b0;
      if (withEnd) mWords++;
      checkOutput("rndRwIdle", read_write, 0);
      checkOutput("rndAck", rd_ack, !curWrite);
      checkOutput("rndWrPtr", wr_ptr, expPtr());
      checkOutput("rndFull", mem_full, expFull());
      applyStimulus();
      checkGrant(curWrite);
    end
    tick();
    endCommand();
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
    checkOutput("rndNoTimeout", timeout_err, 0);

    // Read whose endcommand never arrives.
    rd_req = 1'b1; rd_addr = 23'h001234;
    waitQuad(6, found);
    rd_req = 1'b0;
    repeat (TIMEOUT) tick();
    checkOutput("t6NotYet", timeout_err, 0);
    checkOutput("t6RwHeld", read_write, 2);
    tick();
    checkOutput("t6Timeout", timeout_err, 1);
    checkOutput("t6RwDropped", read_write, 0);
    checkOutput("t6NoAck", rd_ack, 0);
    tick();
    checkOutput("t6NoAckLate", rd_ack, 0);
    rd_req = 1'b1; rd_addr = 23'h002222;
    waitQuad(6, found);
    checkOutput("t6NextRw", read_write, 2);
    checkOutput("t6NextAddr", address, 23'h002222);
    rd_req = 1'b0;
    tick();
    endCommand();
    checkOutput("t6NextAck", rd_ack, 1);
    checkOutput("t6Sticky", timeout_err, 1);

    // Asynchronous reset in the middle of a write burst.
    wr_req = 1'b1;
    waitQuad(6, found);
    wr_req = 1'b0;
    tick();
    pulseWrite();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arstAddress", address, 0);
    checkOutput("arstReadWrite", read_write, 0);
    checkOutput("arstQuad", quad_start, 0);
    checkOutput("arstBurst", burst_mode, 0);
    checkOutput("arstStop", stop_acquisition, 0);
    checkOutput("arstRdAck", rd_ack, 0);
    checkOutput("arstWrPtr", wr_ptr, 0);
    checkOutput("arstFull", mem_full, 0);
    checkOutput("arstTimeout", timeout_err, 0);
    checkOutput("arstBusy", busy, 0);
    repeat (2) tick();

    // After reset, the first grant waits 32 cycles when no endcommand is seen.
    wr_req = 1'b1;
    rst_n = 1'b1;
    quadCount = 0;
    repeat (30) begin
      tick();
      if (quad_start) quadCount++;
    end
    checkOutput("settleHold", quadCount, 0);
    waitQuad(15, found);
    checkOutput("settleRw", read_write, 1);
    checkOutput("settleAddr", address, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
